// File: rtl/mem_access_unit.sv
// Data-side memory access sequencer: issues one load/store per MEM-stage request,
// stalls the pipeline until the memory response, and formats load results.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_req,
  input  logic        mem_write_req,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] mem_address,
  input  logic [1:0]  mem_address_last_two_bits,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_mbe,
  input  logic [31:0] data_rdata,
  input  logic        data_resp,
  output logic        stall_mem,
  output logic [31:0] load_data,
  output logic        load_valid
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [2:0]  funct3_p0;
  logic [1:0]  offset_p0;
  logic        is_read_p0;

  // Halfword lanes follow offset[1] only, matching the 0011/1100 store enables.
  function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    byte_s = word[{off, 3'b000} +: 8];
    half_s = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  format_load = {{24{byte_s[7]}}, byte_s};
      3'b100:  format_load = {24'd0, byte_s};
      3'b001:  format_load = {{16{half_s[15]}}, half_s};
      3'b101:  format_load = {16'd0, half_s};
      default: format_load = word;
    endcase
  endfunction

  assign stall_mem = ((state == IDLE) && (mem_read_req || mem_write_req)) || (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      data_read  <= 1'b0;
      data_write <= 1'b0;
      data_addr  <= 32'd0;
      data_wdata <= 32'd0;
      data_mbe   <= 4'd0;
      funct3_p0  <= 3'd0;
      offset_p0  <= 2'd0;
      is_read_p0 <= 1'b0;
      load_data  <= 32'd0;
      load_valid <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      case (state)
        // Request capture: a store wins when both request lines are high.
        IDLE: begin
          if (mem_read_req || mem_write_req) begin
            data_addr  <= mem_address;
            data_wdata <= mem_wdata;
            data_mbe   <= mem_byte_enable;
            funct3_p0  <= funct3_mem;
            offset_p0  <= mem_address_last_two_bits;
            is_read_p0 <= !mem_write_req;
            data_write <= mem_write_req;
            data_read  <= !mem_write_req;
            state      <= BUSY;
          end
        end
        // Response stage: drop the handshake and register the formatted load.
        BUSY: begin
          if (data_resp) begin
            data_read  <= 1'b0;
            data_write <= 1'b0;
            if (is_read_p0) begin
              load_data  <= format_load(funct3_p0, offset_p0, data_rdata);
              load_valid <= 1'b1;
            end
            state <= DONE;
          end
        end
        // DONE always returns to IDLE so a still-held request is never re-issued.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
